data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and sequencer that shares the single data memory between the core load/store port (port 0) and a loader/debug master (port 1). It accepts a held-request handshake from each port and grants round-robin. It drives one memory command per grant and returns read data after a configurable memory read latency. It sits between the core/loader and data memory in the processor top, and stalls all grants until the clock generator reports lock.

## Interface
- DWIDTH, 32: address and data width.
- RD_LAT, 1: memory read latency in cycles, legal 1..4; cycles from command issue until Mem_Data_Read is valid.
- Clk_Core  in  1  single clock; all logic on the rising edge.
- Rst_Core  in  1  synchronous, active-high reset.
- Locked  in  1  clock-generator lock; while 0, no new grant is issued.
- P0_Req / P1_Req  in  1 each  request; held high with a stable payload until that port's Gnt.
- P0_Wen / P1_Wen  in  1 each  1 = write, 0 = read.
- P0_Wstrb / P1_Wstrb  in  4 each  byte-write strobes; ignored on reads.
- P0_Addr / P1_Addr  in  DWIDTH each  byte address.
- P0_Wdata / P1_Wdata  in  DWIDTH each  write data.
- P0_Gnt / P1_Gnt  out  1 each  one-cycle pulse; command accepted and driven to memory this cycle.
- P0_Rvalid / P1_Rvalid  out  1 each  one-cycle pulse; that port's Rdata is valid.
- P0_Rdata / P1_Rdata  out  DWIDTH each  registered read data; holds its value between responses.
- Mem_Read_Ctrl  out  1  memory read enable.
- Mem_Write_Ctrl  out  4  memory byte-write enables.
- Mem_Data_Addr  out  DWIDTH  memory address.
- Mem_Data_Write  out  DWIDTH  memory write data.
- Mem_Data_Read  in  DWIDTH  memory read data.
- Busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - If Locked=1 and at least one Req is high, pick a winner.
  - Latch the winner's Wen, Wstrb, Addr and Wdata, and store the winner index in sel.
  - Go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration is round-robin on register last (reset value 1, so port 0 wins the first tie).
  - Single requester: that requester wins.
  - Both requesting: the port != last wins.
  - last updates to sel on each entry to ISSUE.
- ISSUE (exactly 1 cycle):
  - Gnt[sel]=1.
  - Mem_Data_Addr and Mem_Data_Write take the latched values.
  - Write: Mem_Write_Ctrl = latched Wstrb, Mem_Read_Ctrl=0; next state IDLE.
  - Read: Mem_Read_Ctrl=1, Mem_Write_Ctrl=0; load the latency counter with RD_LAT; next state WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, capture Mem_Data_Read into Rdata[sel] at the clock edge; next state RESP.
- RESP (1 cycle): Rvalid[sel]=1; next state IDLE.
- Outside ISSUE, Mem_Read_Ctrl=0 and Mem_Write_Ctrl=0. Mem_Data_Addr and Mem_Data_Write hold their last values.
- A write with Wstrb=0 is granted and issued as a no-op write with no Rvalid.
- The non-selected port's Rdata is never modified.
- Req is sampled only in IDLE. A port whose Req drops before its Gnt is a protocol violation, but the latched command is still issued.

## Timing
- Reset values: state=IDLE, last=1, all Gnt=0, all Rvalid=0, P0_Rdata=P1_Rdata=0, Mem_Read_Ctrl=0, Mem_Write_Ctrl=0, Mem_Data_Addr=0, Mem_Data_Write=0, Busy=0.
- Reset in any state: next cycle is IDLE with the reset values above. An in-flight read is discarded and produces no Rvalid.
- With Req high in IDLE at cycle T:
  - Gnt at T+1.
  - Write occupies cycles T..T+1; the next arbitration happens at T+2.
  - Read: data is sampled at the end of cycle T+1+RD_LAT; Rvalid/Rdata appear at T+2+RD_LAT; the next arbitration happens at T+3+RD_LAT.
- Locked dropping mid-transaction does not abort the transaction; it only blocks the next IDLE grant.
- The requester may change its payload or deassert Req in the cycle after Gnt. Keeping Req high issues a new request, which is arbitrated at the next IDLE.

## Test plan
- Reset, then P0 write Addr=0x10, Wdata=0xDEADBEEF, Wstrb=0xF -> Gnt0 at cycle 1, Mem_Write_Ctrl=0xF with Mem_Data_Addr=0x10 that same cycle, Busy low at cycle 2.
- P0 read Addr=0x10 with RD_LAT=1 and memory model returning 0xDEADBEEF -> Mem_Read_Ctrl at cycle 1, P0_Rvalid with P0_Rdata=0xDEADBEEF at cycle 3, P1_Rdata stays 0. Repeat with RD_LAT=4: Rvalid at cycle 6.
- P0 and P1 both hold continuous reads -> grants alternate P0, P1, P0, P1 starting with P0; each Rvalid goes only to the granted port.
- Locked=0 with both Req high for 10 cycles -> no Gnt and Busy=0; Locked rises -> Gnt0 on the next cycle.
- Rst_Core asserted during WAIT of a P1 read -> no P1_Rvalid, all outputs at reset values, and the next tie is granted to P0.
- P1 write with Wstrb=0x3 -> Mem_Write_Ctrl=0x3 for exactly one cycle, no Rvalid, Mem_Read_Ctrl remains 0 throughout.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one data memory between the core
// load/store port (0) and the loader/debug port (1); outputs are registered.
module data_mem_arbiter #(
  parameter int DWIDTH = 32,
  parameter int RD_LAT = 1
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic              Locked,
  input  logic              P0_Req,
  input  logic              P0_Wen,
  input  logic [3:0]        P0_Wstrb,
  input  logic [DWIDTH-1:0] P0_Addr,
  input  logic [DWIDTH-1:0] P0_Wdata,
  output logic              P0_Gnt,
  output logic              P0_Rvalid,
  output logic [DWIDTH-1:0] P0_Rdata,
  input  logic              P1_Req,
  input  logic              P1_Wen,
  input  logic [3:0]        P1_Wstrb,
  input  logic [DWIDTH-1:0] P1_Addr,
  input  logic [DWIDTH-1:0] P1_Wdata,
  output logic              P1_Gnt,
  output logic              P1_Rvalid,
  output logic [DWIDTH-1:0] P1_Rdata,
  output logic              Mem_Read_Ctrl,
  output logic [3:0]        Mem_Write_Ctrl,
  output logic [DWIDTH-1:0] Mem_Data_Addr,
  output logic [DWIDTH-1:0] Mem_Data_Write,
  input  logic [DWIDTH-1:0] Mem_Data_Read,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic              last, last_nx;
  logic              sel, sel_nx;
  logic              wen_q, wen_nx;
  logic              winner;
  logic              capture;
  logic [2:0]        cnt, cnt_nx;
  logic [1:0]        gnt_nx, rvalid_nx;
  logic              rd_nx;
  logic [3:0]        wr_nx;
  logic [DWIDTH-1:0] addr_nx, wdata_nx;

  // The memory command registers double as the latched address/data, and the
  // command is decided on the IDLE->ISSUE edge so it is visible during ISSUE.
  always_comb begin
    state_nx  = state;
    last_nx   = last;
    sel_nx    = sel;
    wen_nx    = wen_q;
    cnt_nx    = cnt;
    capture   = 1'b0;
    gnt_nx    = '0;
    rvalid_nx = '0;
    rd_nx     = 1'b0;
    wr_nx     = '0;
    addr_nx   = Mem_Data_Addr;
    wdata_nx  = Mem_Data_Write;
    winner    = (P0_Req && P1_Req) ? ~last : P1_Req;
    case (state)
      IDLE: begin
        if (Locked && (P0_Req || P1_Req)) begin
          state_nx       = ISSUE;
          sel_nx         = winner;
          last_nx        = winner;
          gnt_nx[winner] = 1'b1;
          wen_nx         = winner ? P1_Wen   : P0_Wen;
          addr_nx        = winner ? P1_Addr  : P0_Addr;
          wdata_nx       = winner ? P1_Wdata : P0_Wdata;
          if (wen_nx) wr_nx = winner ? P1_Wstrb : P0_Wstrb;
          else        rd_nx = 1'b1;
        end
      end
      ISSUE: begin
        if (wen_q) begin
          state_nx = IDLE;
        end else begin
          state_nx = WAIT;
          cnt_nx   = 3'(RD_LAT);
        end
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          capture        = 1'b1;
          rvalid_nx[sel] = 1'b1;
          state_nx       = RESP;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state          <= IDLE;
      last           <= 1'b1;
      sel            <= 1'b0;
      wen_q          <= 1'b0;
      cnt            <= '0;
      P0_Gnt         <= 1'b0;
      P1_Gnt         <= 1'b0;
      P0_Rvalid      <= 1'b0;
      P1_Rvalid      <= 1'b0;
      P0_Rdata       <= '0;
      P1_Rdata       <= '0;
      Mem_Read_Ctrl  <= 1'b0;
      Mem_Write_Ctrl <= '0;
      Mem_Data_Addr  <= '0;
      Mem_Data_Write <= '0;
      Busy           <= 1'b0;
    end else begin
      state          <= state_nx;
      last           <= last_nx;
      sel            <= sel_nx;
      wen_q          <= wen_nx;
      cnt            <= cnt_nx;
      P0_Gnt         <= gnt_nx[0];
      P1_Gnt         <= gnt_nx[1];
      P0_Rvalid      <= rvalid_nx[0];
      P1_Rvalid      <= rvalid_nx[1];
      Mem_Read_Ctrl  <= rd_nx;
      Mem_Write_Ctrl <= wr_nx;
      Mem_Data_Addr  <= addr_nx;
      Mem_Data_Write <= wdata_nx;
      Busy           <= (state_nx != IDLE);
      if (capture) begin
        if (sel) P1_Rdata <= Mem_Data_Read;
        else     P0_Rdata <= Mem_Data_Read;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter: two instances (read latency 1 and 4)
// each checked cycle by cycle against a transaction-schedule reference model.
module tb_data_mem_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 4;
  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        locked;
  logic        req   [2][2];
  logic        wen   [2][2];
  logic [3:0]  strb  [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic        gnt   [2][2];
  logic        rvalid[2][2];
  logic [31:0] rdata [2][2];
  logic        mrd   [2];
  logic [3:0]  mwr   [2];
  logic [31:0] maddr [2];
  logic [31:0] mwdata[2];
  logic [31:0] mrdata[2];
  logic        busy  [2];

  always #5 clk = ~clk;

  data_mem_arbiter #(.DWIDTH(32), .RD_LAT(LAT0)) u_dut_l1 (
    .Clk_Core(clk), .Rst_Core(rst), .Locked(locked),
    .P0_Req(req[0][0]), .P0_Wen(wen[0][0]), .P0_Wstrb(strb[0][0]),
    .P0_Addr(addr[0][0]), .P0_Wdata(wdata[0][0]),
    .P0_Gnt(gnt[0][0]), .P0_Rvalid(rvalid[0][0]), .P0_Rdata(rdata[0][0]),
    .P1_Req(req[0][1]), .P1_Wen(wen[0][1]), .P1_Wstrb(strb[0][1]),
    .P1_Addr(addr[0][1]), .P1_Wdata(wdata[0][1]),
    .P1_Gnt(gnt[0][1]), .P1_Rvalid(rvalid[0][1]), .P1_Rdata(rdata[0][1]),
    .Mem_Read_Ctrl(mrd[0]), .Mem_Write_Ctrl(mwr[0]), .Mem_Data_Addr(maddr[0]),
    .Mem_Data_Write(mwdata[0]), .Mem_Data_Read(mrdata[0]), .Busy(busy[0])
  );

  data_mem_arbiter #(.DWIDTH(32), .RD_LAT(LAT1)) u_dut_l4 (
    .Clk_Core(clk), .Rst_Core(rst), .Locked(locked),
    .P0_Req(req[1][0]), .P0_Wen(wen[1][0]), .P0_Wstrb(strb[1][0]),
    .P0_Addr(addr[1][0]), .P0_Wdata(wdata[1][0]),
    .P0_Gnt(gnt[1][0]), .P0_Rvalid(rvalid[1][0]), .P0_Rdata(rdata[1][0]),
    .P1_Req(req[1][1]), .P1_Wen(wen[1][1]), .P1_Wstrb(strb[1][1]),
    .P1_Addr(addr[1][1]), .P1_Wdata(wdata[1][1]),
    .P1_Gnt(gnt[1][1]), .P1_Rvalid(rvalid[1][1]), .P1_Rdata(rdata[1][1]),
    .Mem_Read_Ctrl(mrd[1]), .Mem_Write_Ctrl(mwr[1]), .Mem_Data_Addr(maddr[1]),
    .Mem_Data_Write(mwdata[1]), .Mem_Data_Read(mrdata[1]), .Busy(busy[1])
  );

  function automatic logic [31:0] init_word(input int i, input int k);
    return 32'hC0DE_0000 ^ (32'(k) * 32'h0001_0101) ^ (32'(i) << 28);
  endfunction

  // Memory models: byte-write, and a read pipe delivering data RD_LAT cycles
  // after the command; anything else on the read bus is junk.
  logic [31:0] tmem[2][16];
  logic [31:0] pd  [2][4];
  logic        pv  [2][4];
  logic [31:0] junk;

  always @(posedge clk) begin
    junk <= $urandom;
    for (int i = 0; i < 2; i++) begin
      pv[i][0] <= mrd[i];
      pd[i][0] <= tmem[i][maddr[i][5:2]];
      for (int k = 1; k < 4; k++) begin
        pv[i][k] <= pv[i][k-1];
        pd[i][k] <= pd[i][k-1];
      end
      if (rst) begin
        for (int k = 0; k < 16; k++) tmem[i][k] <= init_word(i, k);
      end else begin
        for (int b = 0; b < 4; b++)
          if (mwr[i][b]) tmem[i][maddr[i][5:2]][8*b +: 8] <= mwdata[i][8*b +: 8];
      end
    end
  end

  assign mrdata[0] = pv[0][LAT0-1] ? pd[0][LAT0-1] : junk;
  assign mrdata[1] = pv[1][LAT1-1] ? pd[1][LAT1-1] : junk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: each granted command is a scheduled transaction with a
  // grant cycle, optional response cycle and the cycle the arbiter is free.
  int          free_at [2];
  int          gnt_cyc [2];
  int          resp_cyc[2];
  logic        t_port  [2];
  logic        t_wen   [2];
  logic [3:0]  t_strb  [2];
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];
  logic [31:0] t_rdata [2];
  logic        last_m  [2];
  logic [31:0] e_addr  [2];
  logic [31:0] e_wdata [2];
  logic [31:0] e_rdata [2][2];
  logic [31:0] smem    [2][16];
  logic        granted_prev[2][2];
  bit          model_on = 0;

  task automatic new_payload(input int i, input int p, input bit rd_only);
    wen[i][p]   = rd_only ? 1'b0 : 1'($urandom_range(0, 1));
    strb[i][p]  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    addr[i][p]  = $urandom;
    wdata[i][p] = $urandom;
  endtask

  task automatic drive(input int c);
    rst = (c < 3) || (c >= 600 && $urandom_range(0, 99) == 0);
    if (c < 400)      locked = 1'b1;
    else if (c < 600) locked = ((c % 60) < 30);
    else if (!locked) locked = ($urandom_range(0, 7) == 0);
    else              locked = ($urandom_range(0, 49) != 0);
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        if (req[i][p] && granted_prev[i][p]) begin
          if (c < 400 || $urandom_range(0, 1) == 1) new_payload(i, p, c < 400);
          else req[i][p] = 1'b0;
        end else if (!req[i][p] && (c < 400 || $urandom_range(0, 3) == 0)) begin
          req[i][p] = 1'b1;
          new_payload(i, p, c < 400);
        end
      end
  endtask

  task automatic compare(input int c);
    for (int i = 0; i < 2; i++) begin
      logic g, rv;
      string pfx;
      pfx = $sformatf("c%0d lat%0d", c, (i == 0) ? LAT0 : LAT1);
      if (c == gnt_cyc[i]) begin
        e_addr[i]  = t_addr[i];
        e_wdata[i] = t_wdata[i];
      end
      if (c == resp_cyc[i]) e_rdata[i][t_port[i]] = t_rdata[i];
      if (!model_on) continue;
      g  = (c == gnt_cyc[i]);
      rv = (c == resp_cyc[i]);
      check_eq({pfx, " gnt0"},   32'(gnt[i][0]),    32'(g && !t_port[i]));
      check_eq({pfx, " gnt1"},   32'(gnt[i][1]),    32'(g && t_port[i]));
      check_eq({pfx, " mem_rd"}, 32'(mrd[i]),       32'(g && !t_wen[i]));
      check_eq({pfx, " mem_wr"}, 32'(mwr[i]),       (g && t_wen[i]) ? 32'(t_strb[i]) : 32'h0);
      check_eq({pfx, " addr"},   maddr[i],          e_addr[i]);
      check_eq({pfx, " wdata"},  mwdata[i],         e_wdata[i]);
      check_eq({pfx, " rvalid0"}, 32'(rvalid[i][0]), 32'(rv && !t_port[i]));
      check_eq({pfx, " rvalid1"}, 32'(rvalid[i][1]), 32'(rv && t_port[i]));
      check_eq({pfx, " rdata0"}, rdata[i][0],       e_rdata[i][0]);
      check_eq({pfx, " rdata1"}, rdata[i][1],       e_rdata[i][1]);
      check_eq({pfx, " busy"},   32'(busy[i]),
               32'(gnt_cyc[i] >= 0 && c >= gnt_cyc[i] && c < free_at[i]));
    end
  endtask

  task automatic model_step(input int c);
    for (int i = 0; i < 2; i++) begin
      int lat;
      lat = (i == 0) ? LAT0 : LAT1;
      granted_prev[i][0] = 1'b0;
      granted_prev[i][1] = 1'b0;
      if (c == gnt_cyc[i]) begin
        granted_prev[i][t_port[i]] = 1'b1;
        if (t_wen[i])
          for (int b = 0; b < 4; b++)
            if (t_strb[i][b]) smem[i][t_addr[i][5:2]][8*b +: 8] = t_wdata[i][8*b +: 8];
      end
      if (rst) begin
        free_at[i]    = c + 1;
        gnt_cyc[i]    = -1;
        resp_cyc[i]   = -1;
        last_m[i]     = 1'b1;
        e_addr[i]     = '0;
        e_wdata[i]    = '0;
        e_rdata[i][0] = '0;
        e_rdata[i][1] = '0;
        for (int k = 0; k < 16; k++) smem[i][k] = init_word(i, k);
      end else if (c >= free_at[i] && locked && (req[i][0] || req[i][1])) begin
        logic w;
        w          = (req[i][0] && req[i][1]) ? !last_m[i] : req[i][1];
        last_m[i]  = w;
        t_port[i]  = w;
        t_wen[i]   = wen[i][w];
        t_strb[i]  = strb[i][w];
        t_addr[i]  = addr[i][w];
        t_wdata[i] = wdata[i][w];
        t_rdata[i] = smem[i][addr[i][w][5:2]];
        gnt_cyc[i] = c + 1;
        if (t_wen[i]) begin
          resp_cyc[i] = -1;
          free_at[i]  = c + 2;
        end else begin
          resp_cyc[i] = c + 2 + lat;
          free_at[i]  = c + 3 + lat;
        end
      end
    end
    if (rst) model_on = 1;
  endtask

  initial begin
    rst    = 1'b1;
    locked = 1'b1;
    for (int i = 0; i < 2; i++) begin
      free_at[i]  = 0;
      gnt_cyc[i]  = -1;
      resp_cyc[i] = -1;
      t_port[i]   = 1'b0;
      t_wen[i]    = 1'b0;
      t_strb[i]   = '0;
      t_addr[i]   = '0;
      t_wdata[i]  = '0;
      t_rdata[i]  = '0;
      last_m[i]   = 1'b1;
      for (int p = 0; p < 2; p++) begin
        req[i][p]          = 1'b0;
        wen[i][p]          = 1'b0;
        strb[i][p]         = '0;
        addr[i][p]         = '0;
        wdata[i][p]        = '0;
        granted_prev[i][p] = 1'b0;
      end
    end
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      drive(c);
      @(negedge clk);
      compare(c);
      model_step(c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
